serial_sub_ctrl: RTL and testbench

//  Bit-serial N-bit subtractor: sequences one full_sub cell over WIDTH cycles, LSB first.

---
 rtl/serial_sub_ctrl_pkg.sv | 20 ++
 rtl/full_sub.sv | 18 +
 rtl/serial_sub_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// rtl/serial_sub_ctrl_pkg.sv - shared FSM encodings and helpers for the serial arithmetic controllers
// Purpose: state encodings shared by the serial subtractor controller
//          (and the planned serial adder controller), plus the signed
//          overflow helper used on the MSB step.
// Ports:   none (package).
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_RSVD = 2'd3   // never entered; recovers to S_IDLE
  } state_e;

  // Signed overflow of a - b - bin, judged from the operand MSBs and the result MSB.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - one-bit full subtractor cell
// Purpose: diff = a - b - c for single bits, with borrow out.
// Ports:   a, b  - operand bits
//          c     - borrow in
//          diff  - difference bit
//          borrow- borrow out (1 when a < b + c)
module full_sub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c;
  assign borrow = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial WIDTH-bit subtractor with valid/ready handshakes
// Purpose: computes diff = a - b - bin LSB first, one full_sub step per cycle,
//          with a registered borrow chain.
// Ports:   clk, rst_n            - clock, asynchronous active-low reset
//          in_valid/in_ready     - operand handshake (accepts only in IDLE)
//          a, b, bin             - minuend, subtrahend, initial borrow
//          out_valid/out_ready   - result handshake (valid in DONE)
//          diff, bout, ovf       - result, final borrow, signed overflow
//          busy                  - high in RUN or DONE
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             step_diff;
  logic             step_borrow;

  full_sub u_full_sub (
    .a      (a_sr_q[0]),
    .b      (b_sr_q[0]),
    .c      (brw_q),
    .diff   (step_diff),
    .borrow (step_borrow)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    brw_d     = brw_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        diff_sr_d = {step_diff, diff_sr_q[WIDTH-1:1]};
        brw_d     = step_borrow;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // MSB step: the shift registers now hold the original operand MSBs
          // in bit 0, so overflow is taken straight from the cell inputs.
          // Result registers load only here, so they hold across IDLE.
          diff_d  = diff_sr_d;
          bout_d  = step_borrow;
          ovf_d   = sub_ovf(a_sr_q[0], b_sr_q[0], step_diff);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      diff_q    <= '0;
      cnt_q     <= '0;
      brw_q     <= 1'b0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      diff_q    <= diff_d;
      cnt_q     <= cnt_d;
      brw_q     <= brw_d;
      bout_q    <= bout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=16
module tb_serial_sub_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid_i  [2];
  logic        out_ready_i [2];
  logic [15:0] a_i         [2];
  logic [15:0] b_i         [2];
  logic        bin_i       [2];
  logic        in_ready_o  [2];
  logic        out_valid_o [2];
  logic        bout_o      [2];
  logic        ovf_o       [2];
  logic        busy_o      [2];
  logic [15:0] diff_o      [2];
  logic [7:0]  diff8;
  logic [15:0] diff16;

  int n_vec = 0;
  int n_err = 0;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_i[0]),
    .in_ready  (in_ready_o[0]),
    .a         (a_i[0][7:0]),
    .b         (b_i[0][7:0]),
    .bin       (bin_i[0]),
    .out_valid (out_valid_o[0]),
    .out_ready (out_ready_i[0]),
    .diff      (diff8),
    .bout      (bout_o[0]),
    .ovf       (ovf_o[0]),
    .busy      (busy_o[0])
  );

  serial_sub_ctrl #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_i[1]),
    .in_ready  (in_ready_o[1]),
    .a         (a_i[1]),
    .b         (b_i[1]),
    .bin       (bin_i[1]),
    .out_valid (out_valid_o[1]),
    .out_ready (out_ready_i[1]),
    .diff      (diff16),
    .bout      (bout_o[1]),
    .ovf       (ovf_o[1]),
    .busy      (busy_o[1])
  );

  always_comb begin
    diff_o[0] = {8'h00, diff8};
    diff_o[1] = diff16;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: true arithmetic on unbounded integers, then reduced to w bits.
  task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       output logic [15:0] d, output logic bo, output logic ov);
    longint unsigned ua, ub, mask, full;
    longint sa, sb, ci, sd, lim;
    ua   = 64'(av);
    ub   = 64'(bv);
    ci   = cv ? 64'sd1 : 64'sd0;
    mask = (64'd1 << w) - 64'd1;
    ua   = ua & mask;
    ub   = ub & mask;
    full = ua - ub - 64'(ci);
    d    = 16'(full & mask);
    bo   = (ua < ub + 64'(ci));
    lim  = 64'sd1 <<< (w - 1);
    sa   = longint'(ua) - (((ua >> (w - 1)) & 64'd1) != 0 ? (lim <<< 1) : 64'sd0);
    sb   = longint'(ub) - (((ub >> (w - 1)) & 64'd1) != 0 ? (lim <<< 1) : 64'sd0);
    sd   = sa - sb - ci;
    ov   = (sd < -lim) || (sd > lim - 64'sd1);
  endtask

  // One full transaction on instance idx. lat counts rising edges from the
  // accept edge (inclusive) to the edge after which out_valid is seen.
  task automatic run_op(input int idx, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input int rdy_pct, input int hold, input bit noise,
                        output logic [15:0] rd, output logic rbo, output logic rov, output int lat);
    int          w;
    int          waited;
    bit          go;
    logic [15:0] md;
    logic        mbo, mov;
    w = (idx == 0) ? 8 : 16;
    model(w, av, bv, cv, md, mbo, mov);
    a_i[idx] = av; b_i[idx] = bv; bin_i[idx] = cv;
    in_valid_i[idx] = 1'b1;
    out_ready_i[idx] = 1'b0;
    chk("in_ready_idle", 64'(in_ready_o[idx]), 64'd1);
    tick();
    lat = 1;
    while (!out_valid_o[idx] && lat <= 200) begin
      chk("in_ready_run", 64'(in_ready_o[idx]), 64'd0);
      in_valid_i[idx] = noise ? 1'($urandom) : 1'b0;
      if (noise) begin
        a_i[idx] = 16'($urandom);
        b_i[idx] = 16'($urandom);
        bin_i[idx] = 1'($urandom);
      end
      tick();
      lat++;
    end
    chk("result_timeout", 64'(out_valid_o[idx]), 64'd1);
    rd = diff_o[idx]; rbo = bout_o[idx]; rov = ovf_o[idx];
    chk("diff", 64'(rd), 64'(md));
    chk("bout", 64'(rbo), 64'(mbo));
    chk("ovf", 64'(rov), 64'(mov));
    waited = 0;
    go = 1'b0;
    while (!go && waited < 300) begin
      if (waited >= hold && $urandom_range(99) < rdy_pct) begin
        go = 1'b1;
      end else begin
        out_ready_i[idx] = 1'b0;
        in_valid_i[idx] = noise ? 1'($urandom) : 1'b0;
        tick();
        waited++;
        chk("hold_valid", 64'(out_valid_o[idx]), 64'd1);
        chk("hold_diff", 64'(diff_o[idx]), 64'(rd));
        chk("hold_bout", 64'(bout_o[idx]), 64'(rbo));
        chk("hold_ovf", 64'(ovf_o[idx]), 64'(rov));
        chk("hold_in_ready", 64'(in_ready_o[idx]), 64'd0);
      end
    end
    in_valid_i[idx] = 1'b0;
    out_ready_i[idx] = 1'b1;
    tick();
    out_ready_i[idx] = 1'b0;
    chk("out_valid_drop", 64'(out_valid_o[idx]), 64'd0);
    chk("in_ready_back", 64'(in_ready_o[idx]), 64'd1);
    chk("busy_clear", 64'(busy_o[idx]), 64'd0);
    chk("retain_diff", 64'(diff_o[idx]), 64'(rd));
  endtask

  initial begin
    logic [15:0] d;
    logic        bo, ov;
    int          lat;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_i[i] = 1'b0; out_ready_i[i] = 1'b0;
      a_i[i] = '0; b_i[i] = '0; bin_i[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 64'(in_ready_o[i]), 64'd1);
      chk("rst_out_valid", 64'(out_valid_o[i]), 64'd0);
      chk("rst_diff", 64'(diff_o[i]), 64'd0);
      chk("rst_bout", 64'(bout_o[i]), 64'd0);
      chk("rst_ovf", 64'(ovf_o[i]), 64'd0);
      chk("rst_busy", 64'(busy_o[i]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1
    run_op(0, 16'h05, 16'h03, 1'b0, 100, 0, 1'b0, d, bo, ov, lat);
    chk("t1_diff", 64'(d), 64'h02);
    chk("t1_bout", 64'(bo), 64'd0);
    chk("t1_ovf", 64'(ov), 64'd0);
    chk("t1_latency", 64'(lat), 64'd9);
    // T2
    run_op(0, 16'h03, 16'h05, 1'b0, 100, 0, 1'b0, d, bo, ov, lat);
    chk("t2_diff", 64'(d), 64'hFE);
    chk("t2_bout", 64'(bo), 64'd1);
    chk("t2_ovf", 64'(ov), 64'd0);
    // T3
    run_op(0, 16'h00, 16'h00, 1'b1, 100, 0, 1'b0, d, bo, ov, lat);
    chk("t3a_diff", 64'(d), 64'hFF);
    chk("t3a_bout", 64'(bo), 64'd1);
    run_op(0, 16'h80, 16'h01, 1'b0, 100, 0, 1'b0, d, bo, ov, lat);
    chk("t3b_diff", 64'(d), 64'h7F);
    chk("t3b_bout", 64'(bo), 64'd0);
    chk("t3b_ovf", 64'(ov), 64'd1);
    // T4: consumer stalls 5 cycles in DONE
    run_op(0, 16'hA5, 16'h3C, 1'b1, 100, 5, 1'b0, d, bo, ov, lat);
    chk("t4_diff", 64'(d), 64'h68);
    chk("t4_latency16", 64'd17, 64'd17 & 64'(lat + 8)); // 8-bit latency 9 plus 8
    // T5: reset in the 4th RUN cycle
    a_i[0] = 16'h55; b_i[0] = 16'h22; bin_i[0] = 1'b0;
    in_valid_i[0] = 1'b1;
    tick();
    in_valid_i[0] = 1'b0;
    repeat (3) tick();
    chk("t5_busy_before", 64'(busy_o[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_in_ready", 64'(in_ready_o[0]), 64'd1);
    chk("t5_out_valid", 64'(out_valid_o[0]), 64'd0);
    chk("t5_busy", 64'(busy_o[0]), 64'd0);
    chk("t5_diff", 64'(diff_o[0]), 64'd0);
    chk("t5_bout", 64'(bout_o[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(0, 16'h10, 16'h01, 1'b0, 100, 0, 1'b0, d, bo, ov, lat);
    chk("t5_next_diff", 64'(d), 64'h0F);
    chk("t5_next_bout", 64'(bo), 64'd0);
    // 16-bit latency
    run_op(1, 16'h8000, 16'h0001, 1'b0, 100, 0, 1'b0, d, bo, ov, lat);
    chk("w16_diff", 64'(d), 64'h7FFF);
    chk("w16_ovf", 64'(ov), 64'd1);
    chk("w16_latency", 64'(lat), 64'd17);
    // T6: randomized traffic on both widths
    for (int n = 0; n < 1000; n++) begin
      int idx;
      idx = n & 1;
      repeat ($urandom_range(2)) begin
        chk("idle_ready", 64'(in_ready_o[idx]), 64'd1);
        tick();
      end
      run_op(idx, 16'($urandom), 16'($urandom), 1'($urandom), 40, 0, 1'b1, d, bo, ov, lat);
      chk("rand_latency", 64'(lat), (idx == 0) ? 64'd9 : 64'd17);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
